// File: rtl/connect_pkg.sv
// Shared types and default constants for the washer cycle controller.
package connect_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN  = 4'd3,
    S_RFILL  = 4'd4,
    S_RINSE  = 4'd5,
    S_RDRAIN = 4'd6,
    S_SPIN   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam int FILL_T_DEF  = 4;
  localparam int WASH_T_DEF  = 8;
  localparam int DRAIN_T_DEF = 3;
  localparam int RINSE_T_DEF = 4;
  localparam int SPIN_T_DEF  = 5;
  localparam int CNT_W_DEF   = 16;

  // Fixed phase order of a run; SPIN hands over to the single DONE cycle.
  function automatic state_t next_phase(input state_t s);
    case (s)
      S_FILL:   return S_WASH;
      S_WASH:   return S_DRAIN;
      S_DRAIN:  return S_RFILL;
      S_RFILL:  return S_RINSE;
      S_RINSE:  return S_RDRAIN;
      S_RDRAIN: return S_SPIN;
      S_SPIN:   return S_DONE;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/connect_phase_timer.sv
// Loadable phase down-counter; holds while disabled, flags terminal count.
module connect_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over counting; counting stops at zero and freezes while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= ld_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/connect.sv
// Washer cycle controller: start qualification, phase sequencing and
// actuator decode with door-open gating.
//
// state  | meaning
// IDLE   | waiting for a qualified start edge
// FILL   | water valve open, FILL_T per load unit
// WASH   | agitator + motor, WASH_T per load unit
// DRAIN  | drain pump, DRAIN_T
// RFILL  | rinse fill, FILL_T per load unit
// RINSE  | agitator + motor, RINSE_T
// RDRAIN | drain pump, DRAIN_T
// SPIN   | motor high speed + pump, SPIN_T
// DONE   | single-cycle end marker, back to IDLE
module connect
  import connect_pkg::*;
#(
  parameter int FILL_T  = FILL_T_DEF,
  parameter int WASH_T  = WASH_T_DEF,
  parameter int DRAIN_T = DRAIN_T_DEF,
  parameter int RINSE_T = RINSE_T_DEF,
  parameter int SPIN_T  = SPIN_T_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door,
  input  logic       start,
  input  logic [1:0] load,
  output logic       agitator,
  output logic       motor,
  output logic       pump,
  output logic       speed,
  output logic       water
);

  state_t           state_q;
  state_t           state_next;
  logic             start_q;
  logic [1:0]       load_r;
  logic             start_ev;
  logic             accept;
  logic [1:0]       load_sel;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_ld;
  logic             tmr_zero;

  function automatic logic [CNT_W-1:0] phase_len(input state_t s, input logic [1:0] l);
    logic [CNT_W-1:0] lw;
    lw = CNT_W'(l);
    case (s)
      S_FILL, S_RFILL:   return CNT_W'(FILL_T) * lw;
      S_WASH:            return CNT_W'(WASH_T) * lw;
      S_DRAIN, S_RDRAIN: return CNT_W'(DRAIN_T);
      S_RINSE:           return CNT_W'(RINSE_T);
      S_SPIN:            return CNT_W'(SPIN_T);
      default:           return '0;
    endcase
  endfunction

  assign start_ev = start && !start_q;
  assign accept   = (state_q == S_IDLE) && start_ev && !door && (load != 2'd0);

  // load_r is only valid after acceptance, so the FILL entry uses the live load.
  assign load_sel = (state_q == S_IDLE) ? load : load_r;
  assign len      = phase_len(state_next, load_sel);
  assign tmr_val  = (len == '0) ? '0 : len - CNT_W'(1);
  assign tmr_ld   = (state_next != state_q);

  connect_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .ld     (tmr_ld),
    .ld_val (tmr_val),
    .en     (!door),
    .zero   (tmr_zero)
  );

  // State register, start edge history and latched load size.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      load_r  <= 2'd0;
    end else begin
      state_q <= state_next;
      start_q <= start;
      if (accept) begin
        load_r <= load;
      end
    end
  end

  // Next state: qualified start leaves IDLE, terminal count with door closed advances.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: if (accept) state_next = S_FILL;
      S_DONE: state_next = S_IDLE;
      default: if (!door && tmr_zero) state_next = next_phase(state_q);
    endcase
  end

  // Actuator decode from state; an open door forces everything off.
  always_comb begin
    agitator = 1'b0;
    motor    = 1'b0;
    pump     = 1'b0;
    speed    = 1'b0;
    water    = 1'b0;
    if (!door) begin
      case (state_q)
        S_FILL, S_RFILL: water = 1'b1;
        S_WASH, S_RINSE: begin
          agitator = 1'b1;
          motor    = 1'b1;
        end
        S_DRAIN, S_RDRAIN: pump = 1'b1;
        S_SPIN: begin
          motor = 1'b1;
          speed = 1'b1;
          pump  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_connect.sv
// Directed bench for the washer controller with an expected-output scoreboard.
module tb_connect;

  logic       clk;
  logic       reset;
  logic       door;
  logic       start;
  logic [1:0] load;
  logic       agitator;
  logic       motor;
  logic       pump;
  logic       speed;
  logic       water;

  // Output vector order: {water, agitator, motor, pump, speed}
  localparam logic [4:0] O_OFF  = 5'b00000;
  localparam logic [4:0] O_FILL = 5'b10000;
  localparam logic [4:0] O_AGIT = 5'b01100;
  localparam logic [4:0] O_PUMP = 5'b00010;
  localparam logic [4:0] O_SPIN = 5'b00111;

  logic [4:0] expq[$];
  int         n_tests;
  int         n_fail;
  int         cyc;

  connect dut (
    .clk      (clk),
    .reset    (reset),
    .door     (door),
    .start    (start),
    .load     (load),
    .agitator (agitator),
    .motor    (motor),
    .pump     (pump),
    .speed    (speed),
    .water    (water)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp_out(input logic [4:0] v, input int n);
    repeat (n) expq.push_back(v);
  endtask

  // Expected outputs of a full door-closed run for load size l, including DONE.
  task automatic exp_run(input int l);
    exp_out(O_FILL, 4 * l);
    exp_out(O_AGIT, 8 * l);
    exp_out(O_PUMP, 3);
    exp_out(O_FILL, 4 * l);
    exp_out(O_AGIT, 4);
    exp_out(O_PUMP, 3);
    exp_out(O_SPIN, 5);
    exp_out(O_OFF, 1);
  endtask

  // Drive inputs just after each rising edge, then compare against the scoreboard.
  task automatic run(input string tag, input int n, input logic rs, input logic st,
                     input logic dr, input logic [1:0] ld);
    logic [4:0] obs;
    logic [4:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = rs;
      start = st;
      door  = dr;
      load  = ld;
      #1;
      cyc++;
      obs = {water, agitator, motor, pump, speed};
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $error("FAIL %s cycle %0d: scoreboard empty, got %b", tag, cyc, obs);
      end else begin
        e = expq.pop_front();
        assert (obs === e) else begin
          n_fail++;
          $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, e);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    door    = 1'b0;
    load    = 2'd0;

    exp_out(O_OFF, 3);
    run("reset", 3, 1'b1, 1'b0, 1'b0, 2'd0);

    // Load 1, start held high after rising: one full run, no restart.
    exp_out(O_OFF, 6);
    run("idle", 6, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_OFF, 1);
    run("start1", 1, 1'b0, 1'b1, 1'b0, 2'd1);
    exp_run(1);
    exp_out(O_OFF, 5);
    run("run_l1", 37, 1'b0, 1'b1, 1'b0, 2'd1);
    exp_out(O_OFF, 2);
    run("release", 2, 1'b0, 1'b0, 1'b0, 2'd1);

    // Load 3; changing load mid-run must not affect the latched size.
    exp_out(O_OFF, 1);
    run("start3", 1, 1'b0, 1'b1, 1'b0, 2'd3);
    exp_run(3);
    exp_out(O_OFF, 2);
    run("run_l3", 66, 1'b0, 1'b0, 1'b0, 2'd1);

    // Rejected starts: empty load, then door open; neither is queued.
    exp_out(O_OFF, 4);
    run("load0", 1, 1'b0, 1'b1, 1'b0, 2'd0);
    run("load0_after", 3, 1'b0, 1'b0, 1'b0, 2'd0);
    exp_out(O_OFF, 7);
    run("door_start", 1, 1'b0, 1'b1, 1'b1, 2'd2);
    run("door_hold", 3, 1'b0, 1'b0, 1'b1, 2'd2);
    run("door_close", 3, 1'b0, 1'b0, 1'b0, 2'd2);

    // Door opened mid-WASH and in the final DRAIN cycle: paused and resumed.
    exp_out(O_OFF, 1);
    run("start_pause", 1, 1'b0, 1'b1, 1'b0, 2'd1);
    exp_out(O_FILL, 4);
    run("p_fill", 4, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_AGIT, 3);
    run("p_wash_a", 3, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_OFF, 5);
    run("p_wash_open", 5, 1'b0, 1'b0, 1'b1, 2'd1);
    exp_out(O_AGIT, 5);
    run("p_wash_b", 5, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_PUMP, 2);
    run("p_drain_a", 2, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_OFF, 2);
    run("p_drain_open", 2, 1'b0, 1'b0, 1'b1, 2'd1);
    exp_out(O_PUMP, 1);
    exp_out(O_FILL, 4);
    exp_out(O_AGIT, 4);
    exp_out(O_PUMP, 3);
    exp_out(O_SPIN, 5);
    exp_out(O_OFF, 3);
    run("p_rest", 20, 1'b0, 1'b0, 1'b0, 2'd1);

    // Reset during SPIN aborts; a fresh start runs a complete cycle.
    exp_out(O_OFF, 1);
    run("start_rst", 1, 1'b0, 1'b1, 1'b0, 2'd1);
    exp_out(O_FILL, 4);
    exp_out(O_AGIT, 8);
    exp_out(O_PUMP, 3);
    exp_out(O_FILL, 4);
    exp_out(O_AGIT, 4);
    exp_out(O_PUMP, 3);
    exp_out(O_SPIN, 2);
    run("r_run", 28, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_SPIN, 1);
    run("r_assert", 1, 1'b1, 1'b0, 1'b0, 2'd1);
    exp_out(O_OFF, 2);
    run("r_after", 2, 1'b0, 1'b0, 1'b0, 2'd1);
    exp_out(O_OFF, 1);
    run("r_restart", 1, 1'b0, 1'b1, 1'b0, 2'd1);
    exp_run(1);
    exp_out(O_OFF, 1);
    run("r_full", 33, 1'b0, 1'b0, 1'b0, 2'd1);

    // Load 2 with a start pulse during FILL: ignored.
    exp_out(O_OFF, 1);
    run("start2", 1, 1'b0, 1'b1, 1'b0, 2'd2);
    exp_run(2);
    exp_out(O_OFF, 2);
    run("s_a", 3, 1'b0, 1'b0, 1'b0, 2'd2);
    run("s_pulse", 1, 1'b0, 1'b1, 1'b0, 2'd2);
    run("s_b", 46, 1'b0, 1'b0, 1'b0, 2'd2);

    n_tests++;
    assert (expq.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/connect.md
# connect

Washing-machine cycle controller: a Moore FSM that, on a start request with the door closed and a non-empty load, sequences fill, wash, drain, rinse fill, rinse, rinse drain and spin. It drives the water valve, agitator, motor, motor-speed select and drain pump. Phase durations are cycle counts, with fill and wash scaled by load size. It is the top-level control block of the washer design and connects directly to the panel/door inputs and the actuator outputs.

## Interface
Parameters:
- FILL_T, 4, fill cycles per load unit (fill and rinse fill)
- WASH_T, 8, wash cycles per load unit
- DRAIN_T, 3, drain cycles (fixed)
- RINSE_T, 4, rinse-agitate cycles (fixed)
- SPIN_T, 5, spin cycles (fixed)
- CNT_W, 16, phase counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- door  in  1  1 = door open, 0 = closed
- start  in  1  start request; rising edge is the trigger
- load  in  2  load size 0..3; 0 = empty
- agitator  out  1  agitator drive
- motor  out  1  drum motor on
- pump  out  1  drain pump on
- speed  out  1  motor speed, 0 = low (wash), 1 = high (spin)
- water  out  1  inlet water valve open

## Operation
- States: IDLE, FILL, WASH, DRAIN, RFILL, RINSE, RDRAIN, SPIN, DONE.
- Outputs are decoded from the state register; any output not listed is 0:
  - FILL, RFILL: water.
  - WASH, RINSE: agitator, motor.
  - DRAIN, RDRAIN: pump.
  - SPIN: motor, speed, pump.
  - IDLE, DONE: all 0.
- Start event: start=1 while start_q=0, where start_q is start registered once.
- Start is accepted only in IDLE, with door=0 and load!=0. The load value is latched into load_r at acceptance. A start event that fails any of these conditions is discarded; it is not queued.
- Phase durations in cycles:
  - FILL and RFILL: FILL_T*load_r.
  - WASH: WASH_T*load_r.
  - DRAIN and RDRAIN: DRAIN_T.
  - RINSE: RINSE_T.
  - SPIN: SPIN_T.
- Phase counter behaviour:
  - On entering a phase the down-counter loads duration-1.
  - It decrements each cycle with door=0.
  - When the count is 0 and door=0, the FSM advances to the next state in the order above.
- Door open in FILL..SPIN pauses the machine:
  - All outputs are forced to 0.
  - State and counter are frozen.
  - Operation resumes on the cycle after door returns to 0.
- DONE lasts exactly 1 cycle and then goes to IDLE, regardless of door. A new run needs a fresh start rising edge; holding start high does not restart.
- Counter arithmetic is unsigned. The maximum product is 3*max(FILL_T,WASH_T), which must fit in CNT_W bits.

## Timing
- Reset (synchronous) puts the block in IDLE with counter=0, load_r=0, start_q=0, and all outputs 0 from the following cycle.
- Reset mid-run aborts immediately; outputs are 0 on the next cycle.
- Reset has priority over every other input.
- Start latency: start rises with the edge sampled at cycle N; the state is FILL after edge N and water=1 during cycle N+1.
- With the door closed the whole run takes a fixed number of cycles: 7 + (2*FILL_T + WASH_T)*load_r + 2*DRAIN_T + RINSE_T + SPIN_T - 7, followed by 1 DONE cycle. This equals the sum of the phase durations.
- A door change takes effect on outputs in the same cycle, since gating is combinational on door. The counter responds on the next edge.
- If the door opens in the final cycle of a phase, that phase is held and does not advance.

## Structure
- Shared package holds the state enum (9 states, 4-bit encoding) and the default phase constants.
- One natural sub-module: phase_timer, a loadable down-counter with hold (load value, enable = !door, zero flag).
- The top level contains the FSM, start edge detect, load latch and output decode/gating.

## Test plan
- Defaults, reset, then door=0, load=1, start rising at cycle 10 and held high:
  - water for 4 cycles, agitator+motor for 8, pump for 3, water for 4, agitator+motor for 4, pump for 3, motor+speed+pump for 5.
  - Then 1 DONE cycle and IDLE with all outputs 0.
  - The held start does not cause a restart.
- load=3 start: FILL lasts 12 cycles and WASH lasts 24; the remaining phases are unchanged.
- load=0 with a start edge, or door=1 with a start edge: the block stays in IDLE with all outputs 0.
- Door opened for 5 cycles in mid-WASH: outputs are 0 during the open period, and WASH resumes with the remaining count, so its total active cycles are still 8.
- Reset asserted during SPIN: the next cycle is IDLE with all outputs 0; a new start edge runs a full cycle.
- Start pulse during a run: ignored; the sequence and durations are unchanged.
